// File: rtl/mem_responder_if.sv
// Load/store port between the pipeline memory stage and the responder.
// The requester drives req_* and reads back req_ready plus the response strobe.
interface mem_if #(
    parameter int WD_SIZE = 32
) ();
    logic               req_valid;
    logic               req_ready;
    logic               req_wr;
    logic [WD_SIZE-1:0] req_addr;
    logic [2:0]         req_size;
    logic [WD_SIZE-1:0] req_wdata;
    logic               resp_valid;
    logic [WD_SIZE-1:0] resp_rdata;
    logic               resp_err;

    modport master (
        output req_valid, req_wr, req_addr, req_size, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wr, req_addr, req_size, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one load/store at a time, waits LATENCY
// cycles, accesses a small word array with RISC-V byte/half/word semantics and
// returns a single-cycle response with read data and an error flag.
module mem_responder #(
    parameter int WD_SIZE   = 32,
    parameter int MEM_WORDS = 8,
    parameter int LATENCY   = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [MEM_WORDS*WD_SIZE-1:0] input_data,
    mem_if.slave                         bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [WD_SIZE-1:0] ADDR_LIMIT = WD_SIZE'(MEM_WORDS * 4);
    localparam logic [3:0] LAT_M1 = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

    // Request is illegal when the size code is unused, a store asks for an
    // unsigned size, the address is misaligned, or it falls outside the array.
    function automatic logic req_error(input logic               wr,
                                       input logic [2:0]         size,
                                       input logic [WD_SIZE-1:0] addr);
        logic e;
        case (size)
            3'b000:  e = 1'b0;
            3'b001:  e = addr[0];
            3'b010:  e = (addr[1:0] != 2'b00);
            3'b100:  e = wr;
            3'b101:  e = wr | addr[0];
            default: e = 1'b1;
        endcase
        e = e | (addr >= ADDR_LIMIT);
        return e;
    endfunction

    // Select the addressed lane of a word and sign- or zero-extend it.
    function automatic logic [WD_SIZE-1:0] load_extend(input logic [WD_SIZE-1:0] word,
                                                       input logic [2:0]         size,
                                                       input logic [1:0]         lane);
        logic [7:0]         b;
        logic [15:0]        h;
        logic [WD_SIZE-1:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            3'b000:  r = {{(WD_SIZE-8){b[7]}}, b};
            3'b001:  r = {{(WD_SIZE-16){h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {{(WD_SIZE-8){1'b0}}, b};
            3'b101:  r = {{(WD_SIZE-16){1'b0}}, h};
            default: r = {WD_SIZE{1'b0}};
        endcase
        return r;
    endfunction

    // Merge store data into the old word, preserving the untouched lanes.
    function automatic logic [WD_SIZE-1:0] store_merge(input logic [WD_SIZE-1:0] old,
                                                       input logic [WD_SIZE-1:0] wdata,
                                                       input logic [2:0]         size,
                                                       input logic [1:0]         lane);
        logic [WD_SIZE-1:0] r;
        r = old;
        case (size)
            3'b000: r[{lane, 3'b000} +: 8] = wdata[7:0];
            3'b001: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            3'b010:  r = wdata;
            default: r = old;
        endcase
        return r;
    endfunction

    logic [1:0]         state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [WD_SIZE-1:0] addr_q, addr_d;
    logic [2:0]         size_q, size_d;
    logic [WD_SIZE-1:0] wdata_q, wdata_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WD_SIZE-1:0] resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic [WD_SIZE-1:0] mem_q [MEM_WORDS];
    logic [WD_SIZE-1:0] mem_d [MEM_WORDS];

    logic               enter_resp_s;
    logic               acc_wr_s;
    logic [WD_SIZE-1:0] acc_addr_s;
    logic [2:0]         acc_size_s;
    logic [WD_SIZE-1:0] acc_wdata_s;
    logic               acc_err_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [WD_SIZE-1:0] acc_word_s;

    // Handshake sequencing: latch the request on accept and count the wait.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        size_d       = size_q;
        wdata_d      = wdata_q;
        enter_resp_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    wr_d    = bus.req_wr;
                    addr_d  = bus.req_addr;
                    size_d  = bus.req_size;
                    wdata_d = bus.req_wdata;
                    if (LATENCY == 0) begin
                        state_d      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = LAT_M1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Access operands: with zero latency the access happens on the accept
    // edge itself, so the live bus fields are used instead of the latches.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_wr_s    = bus.req_wr;
            acc_addr_s  = bus.req_addr;
            acc_size_s  = bus.req_size;
            acc_wdata_s = bus.req_wdata;
        end else begin
            acc_wr_s    = wr_q;
            acc_addr_s  = addr_q;
            acc_size_s  = size_q;
            acc_wdata_s = wdata_q;
        end
        acc_idx_s  = acc_addr_s[IDX_W+1:2];
        acc_word_s = mem_q[acc_idx_s];
        acc_err_s  = req_error(acc_wr_s, acc_size_s, acc_addr_s);
    end

    // Array write and response formation on the edge that enters RESP.
    always_comb begin
        mem_d        = mem_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = {WD_SIZE{1'b0}};
        resp_err_d   = 1'b0;
        if (enter_resp_s) begin
            resp_valid_d = 1'b1;
            resp_err_d   = acc_err_s;
            if (acc_err_s) begin
                resp_rdata_d = {WD_SIZE{1'b0}};
            end else if (acc_wr_s) begin
                mem_d[acc_idx_s] = store_merge(acc_word_s, acc_wdata_s, acc_size_s,
                                               acc_addr_s[1:0]);
            end else begin
                resp_rdata_d = load_extend(acc_word_s, acc_size_s, acc_addr_s[1:0]);
            end
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // State, request latches and response registers; reset abandons any request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            wr_q         <= 1'b0;
            addr_q       <= {WD_SIZE{1'b0}};
            size_q       <= 3'b000;
            wdata_q      <= {WD_SIZE{1'b0}};
            resp_valid_q <= 1'b0;
            resp_rdata_q <= {WD_SIZE{1'b0}};
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            wdata_q      <= wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Memory array; reset reloads the initial image.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= input_data[WD_SIZE*i +: WD_SIZE];
            end
        end else begin
            for (int i = 0; i < MEM_WORDS; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule
